// File: rtl/sm3_msg_byte_packer_if.sv
// Purpose : byte-serial message input bus plus packed-word output bus of the SM3 message byte packer.
// Ports   : byte_inpt_* (byte stream with valid/ready/last), msg_inpt_* (packed word with lane mask,
//           valid/ready/last), msg_byte_num (total message length in bytes, reported with the last word).
// Modports: master = message source and word sink; slave = the packer itself.
interface sm3_msg_byte_packer_if #(
    parameter int OUT_DW = 32
);
    localparam int BYTE_NUM = OUT_DW / 8;

    logic [7:0]          byte_inpt_d;
    logic                byte_inpt_vld;
    logic                byte_inpt_lst;
    logic                byte_inpt_rdy;

    logic [OUT_DW-1:0]   msg_inpt_d;
    logic [BYTE_NUM-1:0] msg_inpt_vld_byte;
    logic                msg_inpt_vld;
    logic                msg_inpt_lst;
    logic                msg_inpt_rdy;
    logic [60:0]         msg_byte_num;

    modport master (
        output byte_inpt_d, byte_inpt_vld, byte_inpt_lst, msg_inpt_rdy,
        input  byte_inpt_rdy, msg_inpt_d, msg_inpt_vld_byte, msg_inpt_vld,
               msg_inpt_lst, msg_byte_num
    );

    modport slave (
        input  byte_inpt_d, byte_inpt_vld, byte_inpt_lst, msg_inpt_rdy,
        output byte_inpt_rdy, msg_inpt_d, msg_inpt_vld_byte, msg_inpt_vld,
               msg_inpt_lst, msg_byte_num
    );
endinterface

// File: rtl/sm3_msg_byte_packer.sv
// Purpose : packs a byte-serial message big-endian into OUT_DW-bit words for the SM3 pad core.
// Latency : a word-completing byte accepted at edge t shows up as msg_inpt_vld after edge t.
// Backpr. : one output word register; byte_inpt_rdy = ~full | msg_inpt_rdy, so a stalled word stalls input.
// Ports   : clk, rst (async, active-high); bus = sm3_msg_byte_packer_if.slave carrying the byte input
//           stream and the packed word output including lane mask, last flag and message byte count.
module sm3_msg_byte_packer #(
    parameter int OUT_DW = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    sm3_msg_byte_packer_if.slave   bus
);
    localparam int BYTE_NUM = OUT_DW / 8;
    localparam int IDX_W    = $clog2(BYTE_NUM);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } out_state_t;

    out_state_t          r_state;
    out_state_t          w_state_nxt;

    logic                r_init;      // holds byte_inpt_rdy low until the first edge after reset
    logic [IDX_W-1:0]    r_idx;
    logic [OUT_DW-1:0]   r_acc;
    logic [60:0]         r_cnt;
    logic [OUT_DW-1:0]   r_out_d;
    logic [BYTE_NUM-1:0] r_out_mask;
    logic                r_out_lst;
    logic [60:0]         r_out_num;

    logic                w_in_fire;
    logic                w_last_lane;
    logic                w_complete;
    logic                w_drain;
    logic [OUT_DW-1:0]   w_word;
    logic [BYTE_NUM-1:0] w_mask;

    assign bus.byte_inpt_rdy = r_init & ((r_state == EMPTY) | bus.msg_inpt_rdy);

    assign w_in_fire   = bus.byte_inpt_vld & bus.byte_inpt_rdy;
    assign w_last_lane = (r_idx == IDX_W'(BYTE_NUM - 1));
    assign w_complete  = w_in_fire & (w_last_lane | bus.byte_inpt_lst);
    assign w_drain     = (r_state == FULL) & bus.msg_inpt_rdy;

    // Accumulator merged with the incoming byte at lane r_idx; lanes after r_idx are forced to zero.
    // The same value feeds the accumulator (partial word) and the output register (completed word).
    always_comb begin
        w_word = '0;
        w_mask = '0;
        for (int i = 0; i < BYTE_NUM; i++) begin
            if (IDX_W'(i) < r_idx) begin
                w_word[OUT_DW-1-8*i -: 8] = r_acc[OUT_DW-1-8*i -: 8];
                w_mask[BYTE_NUM-1-i]      = 1'b1;
            end else if (IDX_W'(i) == r_idx) begin
                w_word[OUT_DW-1-8*i -: 8] = bus.byte_inpt_d;
                w_mask[BYTE_NUM-1-i]      = 1'b1;
            end
        end
    end

    // Output register occupancy. A completion while FULL implies the drain happened too
    // (input is only ready then), so the register reloads without a bubble.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            EMPTY:   if (w_complete) w_state_nxt = FULL;
            FULL:    if (w_complete) w_state_nxt = FULL;
                     else if (w_drain) w_state_nxt = EMPTY;
            default: w_state_nxt = EMPTY;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_init     <= 1'b0;
            r_idx      <= '0;
            r_acc      <= '0;
            r_cnt      <= '0;
            r_out_d    <= '0;
            r_out_mask <= '0;
            r_out_lst  <= 1'b0;
            r_out_num  <= '0;
        end else begin
            r_init <= 1'b1;
            if (w_in_fire) begin
                r_cnt <= bus.byte_inpt_lst ? '0 : r_cnt + 61'd1;
                if (w_complete) begin
                    r_idx <= '0;
                    r_acc <= '0;
                end else begin
                    r_idx <= r_idx + IDX_W'(1);
                    r_acc <= w_word;
                end
            end
            // Output fields only change on a new word, so they stay stable while stalled or drained.
            if (w_complete) begin
                r_out_d    <= w_word;
                r_out_mask <= w_mask;
                r_out_lst  <= bus.byte_inpt_lst;
                r_out_num  <= bus.byte_inpt_lst ? r_cnt + 61'd1 : '0;
            end
        end
    end

    assign bus.msg_inpt_d        = r_out_d;
    assign bus.msg_inpt_vld_byte = r_out_mask;
    assign bus.msg_inpt_vld      = (r_state == FULL);
    assign bus.msg_inpt_lst      = r_out_lst;
    assign bus.msg_byte_num      = r_out_num;

    // A presented word always carries at least one byte.
    a_mask_nonzero: assert property (@(posedge clk) disable iff (rst)
        (r_state == FULL) |-> (r_out_mask != '0));

endmodule

// File: tb/tb_sm3_msg_byte_packer.sv
module tb_sm3_msg_byte_packer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sm3_msg_byte_packer_if #(.OUT_DW(32)) if32 ();
    sm3_msg_byte_packer_if #(.OUT_DW(64)) if64 ();

    sm3_msg_byte_packer #(.OUT_DW(32)) dut32 (.clk(clk), .rst(rst), .bus(if32));
    sm3_msg_byte_packer #(.OUT_DW(64)) dut64 (.clk(clk), .rst(rst), .bus(if64));

    int n_chk = 0;
    int n_err = 0;

    task automatic check(input string nm, input logic [159:0] act, input logic [159:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // ---------------- reference model: bytes left-aligned in a 64-bit word ----------------
    typedef struct packed {
        logic [63:0] d;
        logic [7:0]  m;
        logic        l;
        logic [60:0] n;
    } word_t;

    word_t       ebuf [2][16];
    int          wr [2];
    int          rd [2];
    logic [63:0] cur_d [2];
    logic [7:0]  cur_m [2];
    int          cur_n [2];
    longint      msg_n [2];

    task automatic model_clear(input int w);
        wr[w] = 0; rd[w] = 0; cur_d[w] = '0; cur_m[w] = '0; cur_n[w] = 0; msg_n[w] = 0;
    endtask

    task automatic model_step(input int w, input int bn,
                              input logic bvld, input logic brdy, input logic [7:0] bd, input logic blst,
                              input logic mvld, input logic mrdy, input logic [63:0] md,
                              input logic [7:0] mk, input logic mlst, input logic [60:0] num);
        word_t got;
        word_t e;
        if (mvld) begin
            check((w == 0) ? "sb32_word_expected" : "sb64_word_expected", rd[w] != wr[w], 1);
            if (rd[w] != wr[w]) begin
                got.d = md; got.m = mk; got.l = mlst; got.n = num;
                check((w == 0) ? "sb32_word" : "sb64_word", got, ebuf[w][rd[w] % 16]);
                if (mrdy) rd[w]++;
            end
        end
        if (bvld && brdy) begin
            cur_d[w] = cur_d[w] | ({56'h0, bd} << (56 - 8 * cur_n[w]));
            cur_m[w] = cur_m[w] | (8'h80 >> cur_n[w]);
            cur_n[w]++;
            msg_n[w]++;
            if (blst || cur_n[w] == bn) begin
                e.d = cur_d[w]; e.m = cur_m[w]; e.l = blst;
                e.n = blst ? msg_n[w][60:0] : 61'd0;
                ebuf[w][wr[w] % 16] = e;
                wr[w]++;
                cur_d[w] = '0; cur_m[w] = '0; cur_n[w] = 0;
                if (blst) msg_n[w] = 0;
            end
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            model_clear(0);
            model_clear(1);
        end else begin
            model_step(0, 4, if32.byte_inpt_vld, if32.byte_inpt_rdy, if32.byte_inpt_d, if32.byte_inpt_lst,
                       if32.msg_inpt_vld, if32.msg_inpt_rdy, {if32.msg_inpt_d, 32'h0},
                       {if32.msg_inpt_vld_byte, 4'h0}, if32.msg_inpt_lst, if32.msg_byte_num);
            model_step(1, 8, if64.byte_inpt_vld, if64.byte_inpt_rdy, if64.byte_inpt_d, if64.byte_inpt_lst,
                       if64.msg_inpt_vld, if64.msg_inpt_rdy, if64.msg_inpt_d,
                       if64.msg_inpt_vld_byte, if64.msg_inpt_lst, if64.msg_byte_num);
        end
    end

    // ---------------- drivers ----------------
    task automatic drv32(input logic v, input logic [7:0] d, input logic l, input logic r);
        if32.byte_inpt_vld = v; if32.byte_inpt_d = d; if32.byte_inpt_lst = l; if32.msg_inpt_rdy = r;
    endtask

    task automatic drv64(input logic v, input logic [7:0] d, input logic l, input logic r);
        if64.byte_inpt_vld = v; if64.byte_inpt_d = d; if64.byte_inpt_lst = l; if64.msg_inpt_rdy = r;
    endtask

    task automatic chk_all_zero(input string nm);
        check({nm, "_32"}, {if32.byte_inpt_rdy, if32.msg_inpt_vld, if32.msg_inpt_d, if32.msg_inpt_vld_byte,
                            if32.msg_inpt_lst, if32.msg_byte_num}, '0);
        check({nm, "_64"}, {if64.byte_inpt_rdy, if64.msg_inpt_vld, if64.msg_inpt_d, if64.msg_inpt_vld_byte,
                            if64.msg_inpt_lst, if64.msg_byte_num}, '0);
    endtask

    // ---------------- directed cycle table (OUT_DW=32) ----------------
    typedef struct {
        logic        v;
        logic [7:0]  d;
        logic        l;
        logic        r;
        logic        e_brdy;
        logic        e_vld;
        logic [31:0] e_d;
        logic [3:0]  e_m;
        logic        e_l;
        logic [60:0] e_n;
    } vec_t;

    function automatic vec_t mk(input logic v, input logic [7:0] d, input logic l, input logic r,
                                input logic eb, input logic ev, input logic [31:0] ed,
                                input logic [3:0] em, input logic el, input logic [60:0] en);
        vec_t t;
        t.v = v; t.d = d; t.l = l; t.r = r; t.e_brdy = eb; t.e_vld = ev;
        t.e_d = ed; t.e_m = em; t.e_l = el; t.e_n = en;
        return t;
    endfunction

    vec_t        tbl [23];
    logic [7:0]  s3 [11];

    initial begin
        drv32(0, 0, 0, 0);
        drv64(0, 0, 0, 0);

        // message "abc", lst on 'c'
        tbl[0]  = mk(1, 8'h61, 0, 1, 1, 0, 0, 0, 0, 0);
        tbl[1]  = mk(1, 8'h62, 0, 1, 1, 0, 0, 0, 0, 0);
        tbl[2]  = mk(1, 8'h63, 1, 1, 1, 0, 0, 0, 0, 0);
        tbl[3]  = mk(0, 8'h00, 0, 1, 1, 1, 32'h61626300, 4'b1110, 1, 3);
        tbl[4]  = mk(0, 8'h00, 0, 1, 1, 0, 0, 0, 0, 0);
        // backpressure: downstream stalls while 4th and 5th bytes arrive
        tbl[5]  = mk(1, 8'h61, 0, 0, 1, 0, 0, 0, 0, 0);
        tbl[6]  = mk(1, 8'h62, 0, 0, 1, 0, 0, 0, 0, 0);
        tbl[7]  = mk(1, 8'h63, 0, 0, 1, 0, 0, 0, 0, 0);
        tbl[8]  = mk(1, 8'h64, 0, 0, 1, 0, 0, 0, 0, 0);
        for (int k = 9; k < 13; k++) tbl[k] = mk(1, 8'h65, 1, 0, 0, 1, 32'h61626364, 4'b1111, 0, 0);
        tbl[13] = mk(1, 8'h65, 1, 1, 1, 1, 32'h61626364, 4'b1111, 0, 0);
        tbl[14] = mk(0, 8'h00, 0, 1, 1, 1, 32'h65000000, 4'b1000, 1, 5);
        tbl[15] = mk(0, 8'h00, 0, 1, 1, 0, 0, 0, 0, 0);
        // drain and completion in the same cycle
        tbl[16] = mk(1, 8'h66, 0, 1, 1, 0, 0, 0, 0, 0);
        tbl[17] = mk(1, 8'h67, 0, 1, 1, 0, 0, 0, 0, 0);
        tbl[18] = mk(1, 8'h68, 0, 1, 1, 0, 0, 0, 0, 0);
        tbl[19] = mk(1, 8'h69, 0, 1, 1, 0, 0, 0, 0, 0);
        tbl[20] = mk(1, 8'h6A, 1, 1, 1, 1, 32'h66676869, 4'b1111, 0, 0);
        tbl[21] = mk(0, 8'h00, 0, 1, 1, 1, 32'h6A000000, 4'b1000, 1, 5);
        tbl[22] = mk(0, 8'h00, 0, 1, 1, 0, 0, 0, 0, 0);

        s3 = '{8'h61, 8'h62, 8'h63, 8'h61, 8'h62, 8'h63, 8'h64, 8'h61, 8'h62, 8'h63, 8'h64};

        // reset state, input ready withheld until the first edge after release
        @(negedge clk);
        @(negedge clk);
        chk_all_zero("reset_outputs");
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check("rel_rdy32", if32.byte_inpt_rdy, 0);
        check("rel_rdy64", if64.byte_inpt_rdy, 0);

        for (int k = 0; k < 23; k++) begin
            @(posedge clk); #1;
            drv32(tbl[k].v, tbl[k].d, tbl[k].l, tbl[k].r);
            @(negedge clk);
            check($sformatf("tbl%0d_brdy", k), if32.byte_inpt_rdy, tbl[k].e_brdy);
            check($sformatf("tbl%0d_vld", k), if32.msg_inpt_vld, tbl[k].e_vld);
            if (tbl[k].e_vld)
                check($sformatf("tbl%0d_word", k),
                      {if32.msg_inpt_d, if32.msg_inpt_vld_byte, if32.msg_inpt_lst, if32.msg_byte_num},
                      {tbl[k].e_d, tbl[k].e_m, tbl[k].e_l, tbl[k].e_n});
        end

        // 64 bytes of "abcd", continuous, one word every 4 cycles
        begin
            int vcnt = 0;
            int rlow = 0;
            int bad  = 0;
            for (int i = 0; i < 66; i++) begin
                @(posedge clk); #1;
                if (i < 64) drv32(1, 8'(8'h61 + (i % 4)), i == 63, 1);
                else        drv32(0, 0, 0, 1);
                @(negedge clk);
                if (i < 64 && !if32.byte_inpt_rdy) rlow++;
                if (if32.msg_inpt_vld) begin
                    vcnt++;
                    if (i == 0 || (i % 4) != 0) bad++;
                end
            end
            check("t2_words", vcnt, 16);
            check("t2_rdy_low", rlow, 0);
            check("t2_spacing", bad, 0);
        end

        // OUT_DW=64: "abc" then "abcdabcd" back to back
        for (int i = 0; i < 13; i++) begin
            @(posedge clk); #1;
            if (i < 11) drv64(1, s3[i], (i == 2) || (i == 10), 1);
            else        drv64(0, 0, 0, 1);
            @(negedge clk);
            if (i == 3)
                check("t3_abc", {if64.msg_inpt_vld, if64.msg_inpt_d, if64.msg_inpt_vld_byte,
                                 if64.msg_inpt_lst, if64.msg_byte_num},
                      {1'b1, 64'h6162630000000000, 8'b11100000, 1'b1, 61'd3});
            if (i == 11)
                check("t3_abcdabcd", {if64.msg_inpt_vld, if64.msg_inpt_d, if64.msg_inpt_vld_byte,
                                      if64.msg_inpt_lst, if64.msg_byte_num},
                      {1'b1, 64'h6162636461626364, 8'hFF, 1'b1, 61'd8});
        end

        // reset in the middle of a message
        @(posedge clk); #1 drv32(1, 8'h70, 0, 1);
        @(posedge clk); #1 drv32(1, 8'h71, 0, 1);
        @(posedge clk); #1 drv32(1, 8'h7A, 0, 1); rst = 1'b1;
        @(negedge clk);
        chk_all_zero("midrst_outputs");
        @(posedge clk); #1 rst = 1'b0; drv32(1, 8'h78, 0, 1);
        @(negedge clk);
        check("midrst_rel_rdy", if32.byte_inpt_rdy, 0);
        @(posedge clk); #1 drv32(1, 8'h78, 0, 1);
        @(negedge clk);
        check("midrst_rdy_up", if32.byte_inpt_rdy, 1);
        @(posedge clk); #1 drv32(1, 8'h79, 1, 1);
        @(posedge clk); #1 drv32(0, 0, 0, 1);
        @(negedge clk);
        check("midrst_word", {if32.msg_inpt_vld, if32.msg_inpt_d, if32.msg_inpt_vld_byte,
                              if32.msg_inpt_lst, if32.msg_byte_num},
              {1'b1, 32'h78790000, 4'b1100, 1'b1, 61'd2});

        // randomized traffic on both widths, checked by the reference model
        for (int i = 0; i < 1500; i++) begin
            @(posedge clk); #1;
            drv32($urandom_range(0, 9) < 7, 8'($urandom), $urandom_range(0, 7) == 0, $urandom_range(0, 9) < 6);
            drv64($urandom_range(0, 9) < 7, 8'($urandom), $urandom_range(0, 11) == 0, $urandom_range(0, 9) < 6);
        end
        @(posedge clk); #1;
        drv32(0, 0, 0, 1);
        drv64(0, 0, 0, 1);
        repeat (6) @(posedge clk);
        @(negedge clk);
        check("sb32_drained", wr[0] - rd[0], 0);
        check("sb64_drained", wr[1] - rd[1], 0);
        check("sb32_vld_idle", if32.msg_inpt_vld, 0);
        check("sb64_vld_idle", if64.msg_inpt_vld, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
